j1_boot_loader: RTL and testbench
=================================

Name: j1_boot_loader

Overview:
- Boot sequencer for the J1 Forth CPU.
- Holds the CPU in reset after power-up and receives a program image as a byte stream from a UART receiver or debug host. It writes the image into the program/data dual-port RAM through a spare write port, checks a checksum, then releases the CPU.
- Sits between the byte source, the dpram8kx16 write port and the CPU's active-high sys_rst_i.

Parameters:
- ADDR_W, 13, word address width of program RAM (depth 2**ADDR_W words).
- TIMEOUT, 24'd5_000_000, cycles to wait for the first header byte before booting the existing RAM image; 0 disables timeout.

Ports:
- sys_clk_i    in   1       system clock
- sys_rst_n_i  in   1       asynchronous active-low reset
- rx_data      in   8       incoming byte
- rx_valid     in   1       rx_data valid
- rx_ready     out  1       byte accepted when rx_valid && rx_ready
- reload       in   1       single-cycle request to re-enter load mode from RUN
- mem_addr     out  ADDR_W  RAM word address
- mem_din      out  16      RAM write data
- mem_we       out  1       RAM write enable, one cycle per word
- cpu_rst      out  1       drives J1 sys_rst_i, active-high
- busy         out  1       high while not in RUN
- err          out  1       sticky frame error flag

Behaviour:
- Reset values: all outputs are registered. Reset gives cpu_rst=1, busy=1, rx_ready=1, mem_we=0, mem_addr=0, mem_din=0, err=0, state=CNT_LO, timeout counter=0.
- Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then N words each as LO byte then HI byte, then CSUM.
- Checksum rule: the XOR of every frame byte, including CNT bytes and CSUM, must equal 8'h00. The running XOR is cleared on entry to CNT_LO.
- State CNT_LO:
  - On handshake, latch count[7:0] and go to CNT_HI.
  - While no byte has arrived and TIMEOUT!=0, the timeout counter increments each cycle. When it reaches TIMEOUT-1, go to RUN with no writes and err unchanged.
- State CNT_HI:
  - Latch count[15:8].
  - If count > 2**ADDR_W: set err=1 and return to CNT_LO.
  - Else if count==0: go to CSUM.
  - Else: go to DAT_LO. Word index is cleared to 0.
- State DAT_LO: latch the low byte and go to DAT_HI.
- State DAT_HI:
  - On handshake, the next cycle has mem_we=1, mem_addr=word index, mem_din={hi,lo}. Write latency is 1 cycle after the HI byte.
  - Increment the word index.
  - If the index equals count, go to CSUM; else go to DAT_LO.
- State CSUM:
  - If the final XOR is 0: err=0, go to RUN.
  - Otherwise: err=1, go to CNT_LO. The image already written stays in RAM; the CPU stays held.
- State RUN:
  - cpu_rst=0, busy=0, rx_ready=0. cpu_rst falls on the clock edge after the CSUM handshake or the timeout expiry.
  - reload=1 gives cpu_rst=1, busy=1, rx_ready=1 from the next cycle and enters CNT_LO with the timeout counter cleared.
  - reload is ignored in all other states.
- mem_we is never asserted outside the cycle following a DAT_HI handshake. mem_addr and mem_din hold their last value otherwise.
- rx_valid may drop between bytes for any number of cycles. No state advances without a handshake, except the timeout.
- Asynchronous reset mid-frame aborts immediately to the reset values. Partially written RAM contents are not cleared.
- Word index width is ADDR_W+1 so that count==2**ADDR_W terminates correctly. The last address written is 2**ADDR_W-1 and does not wrap.

Test Plan:
- Good frame: bytes 02 00 34 12 CD AB 42 -> mem_we pulses with addr 0 data 16'h1234, then addr 1 data 16'hABCD (each 1 cycle after its HI byte); cpu_rst falls 1 cycle after byte 42; err=0, rx_ready=0.
- Bad checksum: same frame with CSUM 43 -> err=1, cpu_rst stays 1, state CNT_LO. Then the good frame is sent -> err=0, cpu_rst=0.
- Timeout: TIMEOUT=100, rx_valid held 0 -> cpu_rst deasserts exactly 100 cycles after reset release; no mem_we, err=0.
- Oversize count: bytes 01 20 (N=8193) -> err=1 after second byte, no mem_we, next byte is treated as CNT_LO.
- Empty frame and reload: bytes 00 00 00 -> RUN with no writes. Then a reload pulse -> cpu_rst=1 and rx_ready=1 next cycle; frame 01 00 EF BE 50 -> addr 0 = 16'hBEEF, run.
- Backpressure and reset: good frame with random 0-5 cycle rx_valid gaps gives results identical to the good-frame case. Asserting sys_rst_n_i low between the two data words -> immediate reset values, and no further mem_we.

Source files
------------

// File: rtl/j1_boot_loader.sv
// j1_boot_loader: holds the J1 in reset, loads a checksummed program image
// from a byte stream into program RAM, then releases the CPU.
module j1_boot_loader #(
   parameter int          ADDR_W  = 13,
   parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_n_i,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              reload,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic              mem_we,
   output logic              cpu_rst,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM, RUN} state_t;

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   state_t            state_q, state_d;
   logic [23:0]       tmo_q, tmo_d;
   logic              tmo_en_q, tmo_en_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        xor_q, xor_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_din_q, mem_din_d;
   logic              mem_we_q, mem_we_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              busy_q, busy_d;
   logic              rx_ready_q, rx_ready_d;
   logic              err_q, err_d;

   logic              hs;
   logic              tmo_hit;
   logic [15:0]       cnt_w;
   logic [ADDR_W:0]   idx_nxt;

   assign hs      = rx_valid && rx_ready_q;
   assign tmo_hit = tmo_en_q && (TIMEOUT != 24'd0) && (tmo_q == TIMEOUT - 24'd1);
   assign cnt_w   = {rx_data, cnt_q[7:0]};
   assign idx_nxt = idx_q + 1'b1;

   // State register
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) state_q <= CNT_LO;
      else              state_q <= state_d;
   end

   // Next-state: every transition needs a handshake except timeout and reload
   always_comb begin
      state_d = state_q;
      case (state_q)
         CNT_LO: begin
            if (hs)           state_d = CNT_HI;
            else if (tmo_hit) state_d = RUN;
         end
         CNT_HI: if (hs) begin
            if ({1'b0, cnt_w} > MAX_WORDS) state_d = CNT_LO;
            else if (cnt_w == 16'd0)       state_d = CSUM;
            else                           state_d = DAT_LO;
         end
         DAT_LO: if (hs) state_d = DAT_HI;
         DAT_HI: if (hs) begin
            if (17'(idx_nxt) == {1'b0, cnt_q}) state_d = CSUM;
            else                                state_d = DAT_LO;
         end
         CSUM:   if (hs) state_d = ((xor_q ^ rx_data) == 8'h00) ? RUN : CNT_LO;
         RUN:    if (reload) state_d = CNT_LO;
         default: state_d = CNT_LO;
      endcase
   end

   // Outputs and datapath next values; control outputs follow the next state
   always_comb begin
      tmo_d      = tmo_q;
      tmo_en_d   = tmo_en_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      lo_d       = lo_q;
      xor_d      = xor_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 1'b0;
      err_d      = err_q;
      cpu_rst_d  = (state_d != RUN);
      busy_d     = (state_d != RUN);
      rx_ready_d = (state_d != RUN);
      case (state_q)
         CNT_LO: begin
            if (hs) begin
               // Loading the first byte directly clears the running XOR
               cnt_d[7:0] = rx_data;
               xor_d      = rx_data;
               tmo_en_d   = 1'b0;
            end else if (tmo_en_q && (TIMEOUT != 24'd0) && !tmo_hit) begin
               tmo_d = tmo_q + 24'd1;
            end
         end
         CNT_HI: if (hs) begin
            cnt_d[15:8] = rx_data;
            xor_d       = xor_q ^ rx_data;
            idx_d       = '0;
            if ({1'b0, cnt_w} > MAX_WORDS) err_d = 1'b1;
         end
         DAT_LO: if (hs) begin
            lo_d  = rx_data;
            xor_d = xor_q ^ rx_data;
         end
         DAT_HI: if (hs) begin
            mem_we_d   = 1'b1;
            mem_addr_d = idx_q[ADDR_W-1:0];
            mem_din_d  = {rx_data, lo_q};
            idx_d      = idx_nxt;
            xor_d      = xor_q ^ rx_data;
         end
         CSUM: if (hs) err_d = ((xor_q ^ rx_data) != 8'h00);
         RUN: if (reload) begin
            tmo_d    = 24'd0;
            tmo_en_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         tmo_q      <= 24'd0;
         tmo_en_q   <= 1'b1;
         cnt_q      <= 16'd0;
         idx_q      <= '0;
         lo_q       <= 8'd0;
         xor_q      <= 8'd0;
         mem_addr_q <= '0;
         mem_din_q  <= 16'd0;
         mem_we_q   <= 1'b0;
         cpu_rst_q  <= 1'b1;
         busy_q     <= 1'b1;
         rx_ready_q <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         tmo_q      <= tmo_d;
         tmo_en_q   <= tmo_en_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         lo_q       <= lo_d;
         xor_q      <= xor_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         cpu_rst_q  <= cpu_rst_d;
         busy_q     <= busy_d;
         rx_ready_q <= rx_ready_d;
         err_q      <= err_d;
      end
   end

   assign rx_ready = rx_ready_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_we   = mem_we_q;
   assign cpu_rst  = cpu_rst_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule

// File: tb/tb_j1_boot_loader.sv
// Bench for j1_boot_loader: scoreboard of expected RAM writes, directed frames.
module tb_j1_boot_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        reload = 1'b0;
   logic [12:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_we;
   logic        cpu_rst, busy, err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   j1_boot_loader #(.ADDR_W(13), .TIMEOUT(24'd100)) dut (
      .sys_clk_i(clk), .sys_rst_n_i(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .reload(reload),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .cpu_rst(cpu_rst), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every write must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         if (exp_q.size() == 0) chk("unexp_we", 32'(mem_addr), 32'hFFFF_FFFF);
         else chk("wr", 32'({mem_addr, mem_din}), exp_q.pop_front());
      end
   end

   task automatic push_wr(input logic [12:0] a, input logic [15:0] d);
      exp_q.push_back(32'({a, d}));
   endtask

   task automatic do_reset();
      rx_valid = 1'b0; reload = 1'b0; rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Offer a byte after `gap` idle cycles; returns at the negedge after the handshake
   task automatic send(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      rx_data = b; rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 50) begin @(negedge clk); n++; end
      if (!rx_ready) chk("hs_timeout", 32'd0, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk("rld_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rld_busy", 32'(busy), 32'd1);
      chk("rld_rx_ready", 32'(rx_ready), 32'd1);
   endtask

   task automatic good_frame(input int maxgap);
      logic [7:0] f [7];
      f = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h42};
      push_wr(13'd0, 16'h1234);
      push_wr(13'd1, 16'hABCD);
      for (int i = 0; i < 7; i++) begin
         if (i == 6) chk("pre_csum_cpu_rst", 32'(cpu_rst), 32'd1);
         send(f[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
         if (i == 3 || i == 5) chk("we_latency", 32'(mem_we), 32'd1);
      end
      chk("gf_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("gf_err", 32'(err), 32'd0);
      chk("gf_rx_ready", 32'(rx_ready), 32'd0);
      chk("gf_busy", 32'(busy), 32'd0);
      chk("gf_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int cnt;
      do_reset();
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_rx_ready", 32'(rx_ready), 32'd1);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_din", 32'(mem_din), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // Good frame
      good_frame(0);

      // Bad checksum, then recovery with the good frame
      pulse_reload();
      push_wr(13'd0, 16'h1234);
      push_wr(13'd1, 16'hABCD);
      send(8'h02, 0); send(8'h00, 0); send(8'h34, 0); send(8'h12, 0);
      send(8'hCD, 0); send(8'hAB, 0); send(8'h43, 0);
      chk("bad_err", 32'(err), 32'd1);
      chk("bad_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("bad_rx_ready", 32'(rx_ready), 32'd1);
      good_frame(0);

      // Oversize count, next byte starts a new (empty) frame
      pulse_reload();
      send(8'h01, 0); send(8'h20, 0);
      chk("ovr_err", 32'(err), 32'd1);
      chk("ovr_cpu_rst", 32'(cpu_rst), 32'd1);
      send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
      chk("empty_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("empty_err", 32'(err), 32'd0);

      // Reload and single-word frame
      pulse_reload();
      push_wr(13'd0, 16'hBEEF);
      send(8'h01, 0); send(8'h00, 0); send(8'hEF, 0); send(8'hBE, 0); send(8'h50, 0);
      chk("one_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("one_err", 32'(err), 32'd0);
      chk("one_drained", 32'(exp_q.size()), 32'd0);

      // Timeout with idle input
      do_reset();
      cnt = 0;
      while (cpu_rst && cnt < 300) begin @(negedge clk); cnt++; end
      chk("tmo_cycles", 32'(cnt), 32'd100);
      chk("tmo_err", 32'(err), 32'd0);
      chk("tmo_busy", 32'(busy), 32'd0);

      // Backpressure: random gaps
      do_reset();
      good_frame(5);

      // Reset between the two data words
      do_reset();
      push_wr(13'd0, 16'h1234);
      send(8'h02, 0); send(8'h00, 0); send(8'h34, 0); send(8'h12, 0);
      send(8'hCD, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("ar_busy", 32'(busy), 32'd1);
      chk("ar_rx_ready", 32'(rx_ready), 32'd1);
      chk("ar_mem_we", 32'(mem_we), 32'd0);
      chk("ar_mem_addr", 32'(mem_addr), 32'd0);
      chk("ar_mem_din", 32'(mem_din), 32'd0);
      chk("ar_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("ar_drained", 32'(exp_q.size()), 32'd0);
      chk("ar_held", 32'(cpu_rst), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
